// File: rtl/unsigned_16by8_div_seq.sv
// Sequential unsigned 16/8 restoring divider with one quotient bit per clock and valid/ready on both sides.
// Build macro APPROX_DIV_EN: run 14 iterations over dividend[15:2] and force the two quotient LSBs to zero.
module unsigned_16by8_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

`ifdef APPROX_DIV_EN
  localparam int ITERS = 14;
`else
  localparam int ITERS = 16;
`endif
  localparam logic [3:0] LAST_COUNT = 4'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  logic [7:0]  rem_reg, rem_next;
  logic [15:0] work_reg, work_next;
  logic [7:0]  divisor_reg, divisor_next;
  logic [15:0] quotient_reg, quotient_next;
  logic [7:0]  remainder_reg, remainder_next;
  logic        dbz_reg, dbz_next;

  logic [8:0]  trial;
  logic        trial_ge;
  logic [7:0]  rem_step;
  logic [15:0] work_step;
  logic [15:0] quotient_final;

  // work_reg shifts dividend bits out of the top while quotient bits enter at the bottom.
  // The 9-bit trial value keeps the compare exact; a restored remainder is always below the divisor.
  always_comb begin
    trial     = {rem_reg, work_reg[15]};
    trial_ge  = (trial >= {1'b0, divisor_reg});
    rem_step  = trial_ge ? 8'(trial - {1'b0, divisor_reg}) : trial[7:0];
    work_step = {work_reg[14:0], trial_ge};
  end

`ifdef APPROX_DIV_EN
  assign quotient_final = {work_step[13:0], 2'b00};
`else
  assign quotient_final = work_step;
`endif

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    rem_next       = rem_reg;
    work_next      = work_reg;
    divisor_next   = divisor_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (divisor == 8'd0) begin
            state_next     = DONE;
            quotient_next  = 16'hFFFF;
            remainder_next = dividend[7:0];
            dbz_next       = 1'b1;
          end else begin
            state_next   = BUSY;
            count_next   = LAST_COUNT;
            rem_next     = 8'd0;
            work_next    = dividend;
            divisor_next = divisor;
          end
        end
      end
      BUSY: begin
        rem_next   = rem_step;
        work_next  = work_step;
        count_next = count_reg - 4'd1;
        if (count_reg == 4'd0) begin
          state_next     = DONE;
          quotient_next  = quotient_final;
          remainder_next = rem_step;
          dbz_next       = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= 4'd0;
      rem_reg       <= 8'd0;
      work_reg      <= 16'd0;
      divisor_reg   <= 8'd0;
      quotient_reg  <= 16'd0;
      remainder_reg <= 8'd0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      rem_reg       <= rem_next;
      work_reg      <= work_next;
      divisor_reg   <= divisor_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule
